// File: rtl/zif_cmd_pkg.sv
// Shared definitions for the ZIF command engine: command codes, FSM states and
// elaboration-time delay arithmetic.
package zif_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_NOP     = 4'd0,
        CMD_READ    = 4'd1,
        CMD_PROGRAM = 4'd2,
        CMD_VPP_ON  = 4'd3,
        CMD_VPP_OFF = 4'd4
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_SAMPLE,
        ST_RECOVER,
        ST_FINISH
    } state_e;

    localparam int DELAY_MAX = 65535;

    // Reload value for the 16-bit delay counter: the state then lasts osc_mhz*us cycles.
    function automatic logic [15:0] delay_cyc(input int osc_mhz, input int us);
        int prod;
        prod = osc_mhz * us;
        return 16'(prod - 1);
    endfunction

    function automatic bit delay_ok(input int osc_mhz, input int us);
        return (osc_mhz * us >= 1) && (osc_mhz * us <= DELAY_MAX);
    endfunction

endpackage

// File: rtl/zif_cmd_if.sv
// Host command handshake plus ZIF socket bus, seen from the host/socket (master)
// and from the engine (slave).
interface zif_cmd_if #(
    parameter int ADDR_W = 16
);
    logic              cmd_run_tgl;
    logic [3:0]        cmd_nr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              cmd_fin_tgl;
    logic              busy;
    logic [7:0]        rdata;
    logic [ADDR_W-1:0] zif_addr;
    logic [7:0]        zif_dout;
    logic              zif_doe;
    logic [7:0]        zif_din;
    logic              zif_ce_n;
    logic              zif_oe_n;
    logic              zif_pgm_n;
    logic              zif_vpp_en;

    modport master (
        output cmd_run_tgl, cmd_nr, cmd_addr, cmd_wdata, zif_din,
        input  cmd_fin_tgl, busy, rdata, zif_addr, zif_dout, zif_doe,
               zif_ce_n, zif_oe_n, zif_pgm_n, zif_vpp_en
    );

    modport slave (
        input  cmd_run_tgl, cmd_nr, cmd_addr, cmd_wdata, zif_din,
        output cmd_fin_tgl, busy, rdata, zif_addr, zif_dout, zif_doe,
               zif_ce_n, zif_oe_n, zif_pgm_n, zif_vpp_en
    );
endinterface

// File: rtl/zif_cmd_toggle_sync.sv
// Two-flop synchroniser for a level/toggle signal crossing into the clk domain.
module toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // NOTE: non-blocking assignments make the two flops a real shift chain; blocking would collapse it to one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/zif_cmd_engine.sv
// Executes host commands as timed EPROM-style bus cycles on the ZIF socket,
// using a toggle handshake (run in, finish out) with the host side.
module zif_cmd_engine
    import zif_cmd_pkg::*;
#(
    parameter int OSC_MHZ       = 24,
    parameter int ADDR_W        = 16,
    parameter int ACC_CYCLES    = 12,
    parameter int PGM_US        = 100,
    parameter int VPP_SETTLE_US = 50
) (
    input  logic     osc,
    input  logic     rst,
    zif_cmd_if.slave bus
);
    localparam logic [15:0] ACC_DLY = delay_cyc(ACC_CYCLES, 1);
    localparam logic [15:0] PGM_DLY = delay_cyc(OSC_MHZ, PGM_US);
    localparam logic [15:0] VPP_DLY = delay_cyc(OSC_MHZ, VPP_SETTLE_US);

    if (!delay_ok(ACC_CYCLES, 1) || !delay_ok(OSC_MHZ, PGM_US) ||
        !delay_ok(OSC_MHZ, VPP_SETTLE_US)) begin : g_delay_range
        $error("zif_cmd_engine: delay parameters exceed the 16-bit counter");
    end

    state_e            r_state, w_state;
    logic [15:0]       r_delay, w_delay;
    logic [3:0]        r_cmd, w_cmd;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [7:0]        r_wdata, w_wdata;
    logic              r_fin, w_fin;
    logic              r_busy, w_busy;
    logic [7:0]        r_rdata, w_rdata;
    logic [ADDR_W-1:0] r_zaddr, w_zaddr;
    logic [7:0]        r_zdout, w_zdout;
    logic              r_doe, w_doe;
    logic              r_ce_n, w_ce_n;
    logic              r_oe_n, w_oe_n;
    logic              r_pgm_n, w_pgm_n;
    logic              r_vpp, w_vpp;
    logic              w_req_s;
    logic              w_pending;

    toggle_sync u_run_sync (
        .clk (osc),
        .rst (rst),
        .i_d (bus.cmd_run_tgl),
        .o_q (w_req_s)
    );

    assign w_pending = (w_req_s != r_fin);

    always_ff @(posedge osc or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_delay <= '0;
            r_cmd   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_fin   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
            r_zaddr <= '0;
            r_zdout <= '0;
            r_doe   <= 1'b0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_pgm_n <= 1'b1;
            r_vpp   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_delay <= w_delay;
            r_cmd   <= w_cmd;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_fin   <= w_fin;
            r_busy  <= w_busy;
            r_rdata <= w_rdata;
            r_zaddr <= w_zaddr;
            r_zdout <= w_zdout;
            r_doe   <= w_doe;
            r_ce_n  <= w_ce_n;
            r_oe_n  <= w_oe_n;
            r_pgm_n <= w_pgm_n;
            r_vpp   <= w_vpp;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case can infer a latch.
        w_state = r_state;
        w_delay = r_delay;
        w_cmd   = r_cmd;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_fin   = r_fin;
        w_busy  = r_busy;
        w_rdata = r_rdata;
        w_zaddr = r_zaddr;
        w_zdout = r_zdout;
        w_doe   = r_doe;
        w_ce_n  = r_ce_n;
        w_oe_n  = r_oe_n;
        w_pgm_n = r_pgm_n;
        w_vpp   = r_vpp;

        if (r_delay != 16'd0) begin
            w_delay = r_delay - 16'd1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pending) begin
                        w_cmd   = bus.cmd_nr;
                        w_addr  = bus.cmd_addr;
                        w_wdata = bus.cmd_wdata;
                        w_busy  = 1'b1;
                        case (bus.cmd_nr)
                            CMD_READ, CMD_PROGRAM: w_state = ST_SETUP;
                            CMD_VPP_ON: begin
                                w_vpp   = 1'b1;
                                w_state = ST_RECOVER;
                            end
                            CMD_VPP_OFF: begin
                                w_vpp   = 1'b0;
                                w_state = ST_RECOVER;
                            end
                            default: w_state = ST_FINISH;
                        endcase
                    end
                end
                ST_SETUP: begin
                    w_zaddr = r_addr;
                    if (r_cmd == CMD_PROGRAM) begin
                        w_zdout = r_wdata;
                        w_doe   = 1'b1;
                    end
                    w_state = ST_STROBE;
                end
                ST_STROBE: begin
                    w_ce_n = 1'b0;
                    if (r_cmd == CMD_READ) begin
                        w_oe_n  = 1'b0;
                        w_delay = ACC_DLY;
                    end else begin
                        w_pgm_n = 1'b0;
                        w_delay = PGM_DLY;
                    end
                    w_state = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (r_cmd == CMD_READ) w_rdata = bus.zif_din;
                    w_ce_n  = 1'b1;
                    w_oe_n  = 1'b1;
                    w_pgm_n = 1'b1;
                    w_doe   = 1'b0;
                    w_state = ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (r_cmd == CMD_VPP_ON || r_cmd == CMD_VPP_OFF) w_delay = VPP_DLY;
                    w_state = ST_FINISH;
                end
                ST_FINISH: begin
                    w_fin   = w_req_s;
                    w_busy  = 1'b0;
                    w_state = ST_IDLE;
                end
                default: w_state = ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_fin_tgl = r_fin;
    assign bus.busy        = r_busy;
    assign bus.rdata       = r_rdata;
    assign bus.zif_addr    = r_zaddr;
    assign bus.zif_dout    = r_zdout;
    assign bus.zif_doe     = r_doe;
    assign bus.zif_ce_n    = r_ce_n;
    assign bus.zif_oe_n    = r_oe_n;
    assign bus.zif_pgm_n   = r_pgm_n;
    assign bus.zif_vpp_en  = r_vpp;
endmodule

// File: tb/tb_zif_cmd_engine.sv
// Randomized self-checking bench for zif_cmd_engine against a command-level
// reference model (per-command latency, strobe widths, read data, VPP state).
module tb_zif_cmd_engine;
    localparam int OSC_MHZ       = 24;
    localparam int ADDR_W        = 16;
    localparam int ACC_CYCLES    = 12;
    localparam int PGM_US        = 100;
    localparam int VPP_SETTLE_US = 50;
    localparam int PGM_CYC       = OSC_MHZ * PGM_US;
    localparam int VPP_CYC       = OSC_MHZ * VPP_SETTLE_US;

    logic osc;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic       m_vpp;
    logic [7:0] m_rdata;

    zif_cmd_if #(.ADDR_W(ADDR_W)) bus ();

    zif_cmd_engine #(
        .OSC_MHZ      (OSC_MHZ),
        .ADDR_W       (ADDR_W),
        .ACC_CYCLES   (ACC_CYCLES),
        .PGM_US       (PGM_US),
        .VPP_SETTLE_US(VPP_SETTLE_US)
    ) dut (
        .osc (osc),
        .rst (rst),
        .bus (bus)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one command via the toggle handshake and checks everything the
    // socket and host sides should show, against the command-level model.
    task automatic do_cmd(input logic [3:0] nr, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] din);
        int   lat, core_lat, exp_ce, exp_oe, exp_pgm;
        int   ce_lo, oe_lo, pgm_lo, bad_addr, bad_pgm, bad_vpp, busy_lo;
        logic fin0, done, is_vpp;

        is_vpp = (nr == 4'd3) || (nr == 4'd4);
        case (nr)
            4'd1:       begin core_lat = 4 + ACC_CYCLES; exp_ce = ACC_CYCLES; exp_oe = ACC_CYCLES; exp_pgm = 0; end
            4'd2:       begin core_lat = 4 + PGM_CYC; exp_ce = PGM_CYC; exp_oe = 0; exp_pgm = PGM_CYC; end
            4'd3, 4'd4: begin core_lat = 1 + VPP_CYC; exp_ce = 0; exp_oe = 0; exp_pgm = 0; end
            default:    begin core_lat = 1; exp_ce = 0; exp_oe = 0; exp_pgm = 0; end
        endcase

        bus.cmd_nr    = nr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.zif_din   = din;
        fin0 = bus.cmd_fin_tgl;
        bus.cmd_run_tgl = ~bus.cmd_run_tgl;

        lat = 0; done = 1'b0;
        ce_lo = 0; oe_lo = 0; pgm_lo = 0; bad_addr = 0; bad_pgm = 0; bad_vpp = 0; busy_lo = 0;
        while (!done && lat < core_lat + 20) begin
            @(negedge osc);
            lat++;
            if (bus.cmd_fin_tgl != fin0) begin
                done = 1'b1;
            end else begin
                if (!bus.zif_ce_n) begin
                    ce_lo++;
                    if (bus.zif_addr !== addr) bad_addr++;
                end
                if (!bus.zif_oe_n) oe_lo++;
                if (!bus.zif_pgm_n) begin
                    pgm_lo++;
                    if (bus.zif_doe !== 1'b1 || bus.zif_dout !== wd) bad_pgm++;
                end
                if (!is_vpp && bus.zif_vpp_en !== m_vpp) bad_vpp++;
                if (lat > 3 && bus.busy !== 1'b1) busy_lo++;
            end
        end

        if (nr == 4'd1) m_rdata = din;
        if (nr == 4'd3) m_vpp = 1'b1;
        if (nr == 4'd4) m_vpp = 1'b0;

        check("finish_seen", 32'(done), 32'd1);
        check("latency_window", 32'(lat >= core_lat + 2 && lat <= core_lat + 3), 32'd1);
        check("ce_low_cycles", 32'(ce_lo), 32'(exp_ce));
        check("oe_low_cycles", 32'(oe_lo), 32'(exp_oe));
        check("pgm_low_cycles", 32'(pgm_lo), 32'(exp_pgm));
        check("addr_during_ce", 32'(bad_addr), 32'd0);
        check("data_during_pgm", 32'(bad_pgm), 32'd0);
        check("vpp_steady", 32'(bad_vpp), 32'd0);
        check("busy_while_running", 32'(busy_lo), 32'd0);
        check("idle_at_finish{ce,oe,pgm,doe,busy}",
              32'({bus.zif_ce_n, bus.zif_oe_n, bus.zif_pgm_n, bus.zif_doe, bus.busy}), 32'b11100);
        check("vpp_at_finish", 32'(bus.zif_vpp_en), 32'(m_vpp));
        check("rdata", 32'(bus.rdata), 32'(m_rdata));
    endtask

    initial begin
        logic fin_start;
        int   n_pgm;
        int   sel;
        int   wait_cnt;
        logic [3:0] nr;

        n_cmp = 0; n_err = 0;
        m_vpp = 1'b0; m_rdata = 8'h00;
        rst = 1'b1;
        bus.cmd_run_tgl = 1'b0;
        bus.cmd_nr = 4'd0;
        bus.cmd_addr = '0;
        bus.cmd_wdata = 8'h00;
        bus.zif_din = 8'h00;

        repeat (3) @(negedge osc);
        check("rst_fin_tgl", 32'(bus.cmd_fin_tgl), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_zif_addr", 32'(bus.zif_addr), 32'd0);
        check("rst_zif_dout_doe", 32'({bus.zif_dout, bus.zif_doe}), 32'd0);
        check("rst_strobes{ce,oe,pgm,vpp}",
              32'({bus.zif_ce_n, bus.zif_oe_n, bus.zif_pgm_n, bus.zif_vpp_en}), 32'b1110);
        rst = 1'b0;
        @(negedge osc);

        do_cmd(4'd1, 16'h1234, 8'h00, 8'hA5);
        do_cmd(4'd2, 16'h0007, 8'h3C, 8'h00);
        do_cmd(4'd3, 16'h0000, 8'h00, 8'h00);
        do_cmd(4'd1, 16'hBEEF, 8'h00, 8'h5A);
        do_cmd(4'hF, 16'hFFFF, 8'hFF, 8'h11);

        fin_start = bus.cmd_fin_tgl;
        do_cmd(4'd1, 16'h0100, 8'h00, 8'hC3);
        @(negedge osc);
        do_cmd(4'd1, 16'h0101, 8'h00, 8'h3C);
        check("b2b_fin_level", 32'(bus.cmd_fin_tgl), 32'(fin_start));

        n_pgm = 0;
        for (int i = 0; i < 20; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 3)      nr = 4'd1;
            else if (sel == 4) nr = (n_pgm < 3) ? 4'd2 : 4'd1;
            else if (sel == 5) nr = 4'd3;
            else if (sel == 6) nr = 4'd4;
            else if (sel == 7) nr = 4'd0;
            else               nr = 4'(int'($urandom_range(5, 15)));
            if (nr == 4'd2) n_pgm++;
            do_cmd(nr, 16'($urandom), 8'($urandom), 8'($urandom));
            repeat (int'($urandom_range(0, 3))) @(negedge osc);
        end

        do_cmd(4'd3, 16'h0000, 8'h00, 8'h00);
        bus.cmd_nr = 4'd2;
        bus.cmd_addr = 16'h0042;
        bus.cmd_wdata = 8'h99;
        bus.cmd_run_tgl = ~bus.cmd_run_tgl;
        wait_cnt = 0;
        while (bus.zif_pgm_n !== 1'b0 && wait_cnt < 20) begin
            @(negedge osc);
            wait_cnt++;
        end
        check("pgm_started", 32'(bus.zif_pgm_n), 32'd0);
        repeat (500) @(negedge osc);
        rst = 1'b1;
        #1;
        check("midrst{pgm_n,ce_n,vpp,busy,fin}",
              32'({bus.zif_pgm_n, bus.zif_ce_n, bus.zif_vpp_en, bus.busy, bus.cmd_fin_tgl}), 32'b11000);
        bus.cmd_run_tgl = 1'b0;
        m_vpp = 1'b0;
        m_rdata = 8'h00;
        repeat (2) @(negedge osc);
        rst = 1'b0;
        repeat (5) @(negedge osc);
        check("post_rst_idle_busy", 32'(bus.busy), 32'd0);
        do_cmd(4'd1, 16'h4321, 8'h00, 8'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
